// File: rtl/rgb_pwm_gen.sv
// Three-channel 8-bit LED PWM generator with a shared clock prescaler and
// period-aligned shadow duty registers, so duty updates never glitch mid-period.
module rgb_pwm_gen #(
    parameter int unsigned PRESCALE = 196,
    parameter bit          INVERT   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] R_time_in,
    input  logic [7:0] G_time_in,
    input  logic [7:0] B_time_in,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       period_start
);

    localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    // The PWM counter stops at 254 so duty 255 stays on for the whole period.
    localparam logic [7:0]       CNT_LAST = 8'd254;

    logic [PRE_W-1:0] r_pre_cnt;
    logic [7:0]       r_pwm_cnt;
    logic [7:0]       r_sh_r;
    logic [7:0]       r_sh_g;
    logic [7:0]       r_sh_b;
    logic             r_pwm_r;
    logic             r_pwm_g;
    logic             r_pwm_b;
    logic             r_period_start;

    logic             w_tick;
    logic             w_wrap;
    logic [PRE_W-1:0] w_pre_nxt;
    logic [7:0]       w_cnt_nxt;

    // Prescaler tick, period wrap and next counter values.
    always_comb begin
        w_tick    = 1'b0;
        w_wrap    = 1'b0;
        w_pre_nxt = r_pre_cnt + PRE_ONE;
        w_cnt_nxt = r_pwm_cnt;
        if (r_pre_cnt == PRE_MAX) begin
            w_pre_nxt = '0;
            w_tick    = en;
        end else begin
            w_tick    = 1'b0;
        end
        if (w_tick) begin
            if (r_pwm_cnt == CNT_LAST) begin
                w_wrap    = 1'b1;
                w_cnt_nxt = 8'd0;
            end else begin
                w_wrap    = 1'b0;
                w_cnt_nxt = r_pwm_cnt + 8'd1;
            end
        end else begin
            w_cnt_nxt = r_pwm_cnt;
        end
    end

    // Counters, shadow duties and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt      <= '0;
            r_pwm_cnt      <= 8'd0;
            r_sh_r         <= 8'd0;
            r_sh_g         <= 8'd0;
            r_sh_b         <= 8'd0;
            r_period_start <= 1'b0;
            r_pwm_r        <= INVERT;
            r_pwm_g        <= INVERT;
            r_pwm_b        <= INVERT;
        end else if (!en) begin
            // Parked: shadows follow the inputs so the first enabled period uses them.
            r_pre_cnt      <= '0;
            r_pwm_cnt      <= 8'd0;
            r_sh_r         <= R_time_in;
            r_sh_g         <= G_time_in;
            r_sh_b         <= B_time_in;
            r_period_start <= 1'b0;
            r_pwm_r        <= INVERT;
            r_pwm_g        <= INVERT;
            r_pwm_b        <= INVERT;
        end else begin
            r_pre_cnt      <= w_pre_nxt;
            r_pwm_cnt      <= w_cnt_nxt;
            if (w_wrap) begin
                r_sh_r <= R_time_in;
                r_sh_g <= G_time_in;
                r_sh_b <= B_time_in;
            end else begin
                r_sh_r <= r_sh_r;
                r_sh_g <= r_sh_g;
                r_sh_b <= r_sh_b;
            end
            r_period_start <= w_wrap;
            r_pwm_r        <= INVERT ^ (r_pwm_cnt < r_sh_r);
            r_pwm_g        <= INVERT ^ (r_pwm_cnt < r_sh_g);
            r_pwm_b        <= INVERT ^ (r_pwm_cnt < r_sh_b);
        end
    end

    assign pwm_r        = r_pwm_r;
    assign pwm_g        = r_pwm_g;
    assign pwm_b        = r_pwm_b;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Bench for rgb_pwm_gen: a PRESCALE=2/INVERT=0 instance and a PRESCALE=1/INVERT=1
// instance share stimulus; both are tracked by a period-position reference model.
module tb_rgb_pwm_gen;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       en   = 1'b0;
    logic [7:0] r_in = 8'd0;
    logic [7:0] g_in = 8'd0;
    logic [7:0] b_in = 8'd0;
    logic       pwm_r, pwm_g, pwm_b, period_start;
    logic       pwm_r1, pwm_g1, pwm_b1, period_start1;

    int n_tests = 0;
    int n_fail  = 0;

    rgb_pwm_gen #(.PRESCALE(2), .INVERT(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en),
        .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
        .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .period_start(period_start)
    );

    rgb_pwm_gen #(.PRESCALE(1), .INVERT(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .en(en),
        .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
        .pwm_r(pwm_r1), .pwm_g(pwm_g1), .pwm_b(pwm_b1), .period_start(period_start1)
    );

    always #5 clk = ~clk;

    // Reference model state: enabled cycles since counting (re)started, shadow duties, outputs.
    int         m_t   [2];
    logic [7:0] m_sh  [2][3];
    logic       m_pwm [2][3];
    logic       m_ps  [2];
    int         m_pre [2];
    logic       m_inv [2];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance model k by one clock edge using the inputs present at that edge.
    task automatic model_edge(input int k);
        int         per;
        int         pos;
        int         tk;
        logic [7:0] din [3];
        din[0] = r_in;
        din[1] = g_in;
        din[2] = b_in;
        if (rst || !en) begin
            m_t[k]  = 0;
            m_ps[k] = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_pwm[k][c] = m_inv[k];
                m_sh[k][c]  = rst ? 8'd0 : din[c];
            end
        end else begin
            per = 255 * m_pre[k];
            pos = m_t[k] % per;
            tk  = pos / m_pre[k];
            for (int c = 0; c < 3; c++)
                m_pwm[k][c] = m_inv[k] ^ (tk < int'(m_sh[k][c]));
            m_ps[k] = (pos == per - 1);
            if (m_ps[k]) begin
                for (int c = 0; c < 3; c++)
                    m_sh[k][c] = din[c];
            end
            m_t[k]++;
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [7:0] rv, input logic [7:0] gv,
                        input logic [7:0] bv);
        @(negedge clk);
        rst  = r;
        en   = e;
        r_in = rv;
        g_in = gv;
        b_in = bv;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("model_p2", int'({period_start, pwm_b, pwm_g, pwm_r}),
              int'({m_ps[0], m_pwm[0][2], m_pwm[0][1], m_pwm[0][0]}));
        check("model_p1_inv", int'({period_start1, pwm_b1, pwm_g1, pwm_r1}),
              int'({m_ps[1], m_pwm[1][2], m_pwm[1][1], m_pwm[1][0]}));
    endtask

    // Run n cycles with fixed inputs, counting high cycles and period_start pulses of dut.
    task automatic run(input int n, input bit e, input logic [7:0] rv, input logic [7:0] gv,
                       input logic [7:0] bv, output int hr, output int hg, output int hb,
                       output int nps, output int fps);
        hr  = 0;
        hg  = 0;
        hb  = 0;
        nps = 0;
        fps = -1;
        for (int i = 1; i <= n; i++) begin
            step(1'b0, e, rv, gv, bv);
            hr += int'(pwm_r);
            hg += int'(pwm_g);
            hb += int'(pwm_b);
            if (period_start) begin
                nps++;
                if (fps < 0) fps = i;
            end
        end
    endtask

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         er;
        int         eg;
        int         eb;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int         hr, hg, hb, nps, fps;
        int         hr2, hg2, hb2, nps2, fps2;
        logic [7:0] rr, gg, bb;

        m_pre[0] = 2;
        m_pre[1] = 1;
        m_inv[0] = 1'b0;
        m_inv[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_t[k]  = 0;
            m_ps[k] = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_sh[k][c]  = 8'd0;
                m_pwm[k][c] = m_inv[k];
            end
        end

        tbl[0] = '{r: 8'd255, g: 8'd128, b: 8'd1,   er: 510, eg: 256, eb: 2};
        tbl[1] = '{r: 8'd0,   g: 8'd0,   b: 8'd0,   er: 0,   eg: 0,   eb: 0};
        tbl[2] = '{r: 8'd10,  g: 8'd200, b: 8'd254, er: 20,  eg: 400, eb: 508};
        tbl[3] = '{r: 8'd64,  g: 8'd0,   b: 8'd255, er: 128, eg: 0,   eb: 510};

        // Reset, with en high to show reset dominates.
        repeat (3) step(1'b1, 1'b1, 8'd255, 8'd255, 8'd255);
        check("rst_outputs_p2", int'({period_start, pwm_b, pwm_g, pwm_r}), 0);
        check("rst_outputs_inv", int'({period_start1, pwm_b1, pwm_g1, pwm_r1}), 7);

        // Zero duty: outputs low, period_start every 510 cycles.
        run(2000, 1'b1, 8'd0, 8'd0, 8'd0, hr, hg, hb, nps, fps);
        check("zero_duty_high", hr + hg + hb, 0);
        check("zero_duty_ps_count", nps, 3);
        check("zero_duty_first_ps", fps, 510);

        // Duty table: shadows loaded while parked, then one full period.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, tbl[i].r, tbl[i].g, tbl[i].b);
            run(510, 1'b1, tbl[i].r, tbl[i].g, tbl[i].b, hr, hg, hb, nps, fps);
            check("tbl_r_high", hr, tbl[i].er);
            check("tbl_g_high", hg, tbl[i].eg);
            check("tbl_b_high", hb, tbl[i].eb);
            check("tbl_ps_at_510", fps, 510);
        end

        // Mid-period duty change is deferred to the next period.
        step(1'b0, 1'b0, 8'd0, 8'd10, 8'd0);
        run(100, 1'b1, 8'd0, 8'd10, 8'd0, hr, hg, hb, nps, fps);
        run(410, 1'b1, 8'd0, 8'd200, 8'd0, hr2, hg2, hb2, nps2, fps2);
        check("midchange_g_cur", hg + hg2, 20);
        run(510, 1'b1, 8'd0, 8'd200, 8'd0, hr, hg, hb, nps, fps);
        check("midchange_g_next", hg, 400);

        // en drop mid-period while red is high.
        step(1'b0, 1'b0, 8'd64, 8'd0, 8'd0);
        run(40, 1'b1, 8'd64, 8'd0, 8'd0, hr, hg, hb, nps, fps);
        check("endrop_r_before", int'(pwm_r), 1);
        step(1'b0, 1'b0, 8'd64, 8'd0, 8'd0);
        check("endrop_r_off", int'(pwm_r), 0);
        run(9, 1'b0, 8'd64, 8'd0, 8'd0, hr, hg, hb, nps, fps);
        run(510, 1'b1, 8'd64, 8'd0, 8'd0, hr, hg, hb, nps, fps);
        check("enrise_r_high", hr, 128);
        check("enrise_first_ps", fps, 510);
        check("enrise_ps_count", nps, 1);

        // Reset mid-period at pwm_cnt=77; shadows come back as zero.
        step(1'b0, 1'b0, 8'd200, 8'd0, 8'd0);
        run(154, 1'b1, 8'd200, 8'd0, 8'd0, hr, hg, hb, nps, fps);
        check("rstmid_r_before", int'(pwm_r), 1);
        step(1'b1, 1'b1, 8'd200, 8'd0, 8'd0);
        check("rstmid_r_off", int'(pwm_r), 0);
        step(1'b1, 1'b1, 8'd200, 8'd0, 8'd0);
        run(510, 1'b1, 8'd200, 8'd0, 8'd0, hr, hg, hb, nps, fps);
        check("rstmid_r_first", hr, 0);
        check("rstmid_first_ps", fps, 510);
        run(510, 1'b1, 8'd200, 8'd0, 8'd0, hr, hg, hb, nps, fps);
        check("rstmid_r_second", hr, 400);

        // Randomized traffic checked against the model every cycle.
        rr = 8'd0;
        gg = 8'd0;
        bb = 8'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       rr = 8'd0;
                    1:       rr = 8'd255;
                    default: rr = 8'($urandom_range(0, 255));
                endcase
                gg = 8'($urandom_range(0, 255));
                bb = ($urandom_range(0, 1) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            end
            step($urandom_range(0, 799) == 0, $urandom_range(0, 699) != 0, rr, gg, bb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
